// File: rtl/adder_operand_injector.sv
// Packetised high-toggle operand source feeding the adder under characterization.
// Optional sum checker is enabled by defining ADDER_INJ_CHECK_EN.
module adder_operand_injector #(
    parameter int N        = 28,
    parameter int PAYLOAD  = 20,
    parameter int GAP      = 7,
    parameter int NUM_PKTS = 10
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic         out_ready,
`ifdef ADDER_INJ_CHECK_EN
    input  logic [N-1:0] sum_in,
    output logic         err,
    output logic [15:0]  err_cnt,
`endif
    output logic         out_valid,
    output logic         out_last,
    output logic [N-1:0] input1,
    output logic [N-1:0] input2,
    output logic         busy,
    output logic         done
);
    localparam int FW = 2 * N;
    localparam int PW = $clog2(FW + 1);
    localparam int CW = $clog2(PAYLOAD + 1);
    localparam int KW = $clog2(NUM_PKTS + 1);
    localparam int GW = $clog2(GAP + 2);

    localparam logic [PW-1:0] LAST_P    = PW'(FW);
    localparam logic [CW-1:0] LAST_FLIT = CW'(PAYLOAD - 1);
    localparam logic [KW-1:0] LAST_PKT  = KW'(NUM_PKTS - 1);
    localparam logic [GW-1:0] LAST_GAP  = GW'((GAP > 0) ? GAP - 1 : 0);

    typedef enum logic [1:0] {S_IDLE, S_SEND, S_GAP, S_DONE} state_t;

    state_t          r_state, w_state;
    logic [CW-1:0]   r_flit_cnt, w_flit_cnt;
    logic [KW-1:0]   r_pkt_cnt, w_pkt_cnt;
    logic [GW-1:0]   r_gap_cnt, w_gap_cnt;
    logic [PW-1:0]   r_p, w_p;
    logic [FW-1:0]   r_flit, w_flit;
    logic            r_valid, w_valid;
    logic            r_last, w_last;
    logic            r_busy, w_busy;
    logic            r_done, w_done;
    logic            w_xfer;
    logic            w_begin_pkt;
    logic            w_finish;

    // Even p: top-aligned run of p ones; odd p: bottom-aligned run of p ones.
    function automatic logic [FW-1:0] f_pattern(input logic [PW-1:0] p);
        logic [FW-1:0] m;
        m = '1;
        return p[0] ? ~(m << p) : ~(m >> p);
    endfunction

    assign w_xfer = r_valid && out_ready;

    always_comb begin
        w_state     = r_state;
        w_flit_cnt  = r_flit_cnt;
        w_pkt_cnt   = r_pkt_cnt;
        w_gap_cnt   = r_gap_cnt;
        w_p         = r_p;
        w_flit      = r_flit;
        w_valid     = r_valid;
        w_last      = r_last;
        w_busy      = r_busy;
        w_done      = r_done;
        w_begin_pkt = 1'b0;
        w_finish    = 1'b0;

        case (r_state)
            S_IDLE, S_DONE: begin
                if (start) begin
                    w_pkt_cnt   = '0;
                    w_begin_pkt = 1'b1;
                end
            end
            S_SEND: begin
                if (w_xfer) begin
                    if (r_flit_cnt == LAST_FLIT) begin
                        if (GAP > 0) begin
                            w_state   = S_GAP;
                            w_gap_cnt = '0;
                            w_valid   = 1'b0;
                            w_last    = 1'b0;
                        end else if (r_pkt_cnt != LAST_PKT) begin
                            w_pkt_cnt   = r_pkt_cnt + 1'b1;
                            w_begin_pkt = 1'b1;
                        end else begin
                            w_finish = 1'b1;
                        end
                    end else begin
                        w_flit_cnt = r_flit_cnt + 1'b1;
                        w_p        = (r_p == LAST_P) ? '0 : r_p + 1'b1;
                        w_flit     = f_pattern(w_p);
                        w_last     = (w_flit_cnt == LAST_FLIT);
                    end
                end
            end
            S_GAP: begin
                if (r_gap_cnt == LAST_GAP) begin
                    if (r_pkt_cnt == LAST_PKT) begin
                        w_finish = 1'b1;
                    end else begin
                        w_pkt_cnt   = r_pkt_cnt + 1'b1;
                        w_begin_pkt = 1'b1;
                    end
                end else begin
                    w_gap_cnt = r_gap_cnt + 1'b1;
                end
            end
            default: w_state = S_IDLE;
        endcase

        // Both the run start and every subsequent packet open with flit p=0.
        if (w_begin_pkt) begin
            w_state    = S_SEND;
            w_flit_cnt = '0;
            w_p        = '0;
            w_flit     = '0;
            w_valid    = 1'b1;
            w_last     = (PAYLOAD == 1);
            w_busy     = 1'b1;
            w_done     = 1'b0;
        end
        if (w_finish) begin
            w_state = S_DONE;
            w_valid = 1'b0;
            w_last  = 1'b0;
            w_busy  = 1'b0;
            w_done  = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_flit_cnt <= '0;
            r_pkt_cnt  <= '0;
            r_gap_cnt  <= '0;
            r_p        <= '0;
            r_flit     <= '0;
            r_valid    <= 1'b0;
            r_last     <= 1'b0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
        end else begin
            r_state    <= w_state;
            r_flit_cnt <= w_flit_cnt;
            r_pkt_cnt  <= w_pkt_cnt;
            r_gap_cnt  <= w_gap_cnt;
            r_p        <= w_p;
            r_flit     <= w_flit;
            r_valid    <= w_valid;
            r_last     <= w_last;
            r_busy     <= w_busy;
            r_done     <= w_done;
        end
    end

    assign out_valid = r_valid;
    assign out_last  = r_last;
    assign input1    = r_flit[N-1:0];
    assign input2    = r_flit[FW-1:N];
    assign busy      = r_busy;
    assign done      = r_done;

`ifdef ADDER_INJ_CHECK_EN
    logic         r_err;
    logic [15:0]  r_err_cnt;
    logic [N-1:0] w_sum_exp;
    logic         w_start_acc;

    assign w_sum_exp   = r_flit[N-1:0] + r_flit[FW-1:N];
    assign w_start_acc = start && (r_state == S_IDLE || r_state == S_DONE);

    always_ff @(posedge clk) begin
        if (rst || w_start_acc) begin
            r_err     <= 1'b0;
            r_err_cnt <= '0;
        end else if (w_xfer && (sum_in != w_sum_exp)) begin
            r_err <= 1'b1;
            if (r_err_cnt != '1) begin
                r_err_cnt <= r_err_cnt + 1'b1;
            end
        end
    end

    assign err     = r_err;
    assign err_cnt = r_err_cnt;
`endif

endmodule

// File: tb/tb_adder_operand_injector.sv
// Directed, table-driven bench for adder_operand_injector (two parameter sets).
module tb_adder_operand_injector;

    logic       clk = 1'b0;
    logic       rst, start, out_ready;
    logic       v1, l1, busy1, done1;
    logic [3:0] a1, b1;
    logic       start2, ready2;
    logic       v2, l2, busy2, done2;
    logic [3:0] a2, b2;
    logic       inj_bad;

    int unsigned total = 0;
    int unsigned bad   = 0;

    always #5 clk = ~clk;

`ifdef ADDER_INJ_CHECK_EN
    logic [3:0]  sum1, sum2;
    logic        err1, err2;
    logic [15:0] ecnt1, ecnt2;
    assign sum1 = (inj_bad && {b1, a1} == 8'h01) ? 4'h0 : a1 + b1;
    assign sum2 = a2 + b2;
`endif

    adder_operand_injector #(.N(4), .PAYLOAD(3), .GAP(2), .NUM_PKTS(2)) dut (
        .clk(clk), .rst(rst), .start(start), .out_ready(out_ready),
`ifdef ADDER_INJ_CHECK_EN
        .sum_in(sum1), .err(err1), .err_cnt(ecnt1),
`endif
        .out_valid(v1), .out_last(l1), .input1(a1), .input2(b1),
        .busy(busy1), .done(done1)
    );

    adder_operand_injector #(.N(4), .PAYLOAD(10), .GAP(0), .NUM_PKTS(1)) dut2 (
        .clk(clk), .rst(rst), .start(start2), .out_ready(ready2),
`ifdef ADDER_INJ_CHECK_EN
        .sum_in(sum2), .err(err2), .err_cnt(ecnt2),
`endif
        .out_valid(v2), .out_last(l2), .input1(a2), .input2(b2),
        .busy(busy2), .done(done2)
    );

    typedef struct {
        logic       st;
        logic       rdy;
        logic       v;
        logic       l;
        logic [7:0] f;
        logic       b;
        logic       d;
    } vec_t;

    vec_t vec[$];

    function automatic void add(input logic st, input logic rdy, input logic v,
                                input logic l, input logic [7:0] f,
                                input logic b, input logic d);
        vec_t e;
        e.st = st; e.rdy = rdy; e.v = v; e.l = l; e.f = f; e.b = b; e.d = d;
        vec.push_back(e);
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Pulses start on dut, then checks and drives one record per cycle.
    task automatic run_table(input string tag, input int first, input int count);
        start     = 1'b1;
        out_ready = 1'b1;
        for (int i = first; i < first + count; i++) begin
            @(negedge clk);
            chk($sformatf("%s_vec%0d", tag, i - first),
                {v1, l1, busy1, done1, (v1 ? {b1, a1} : 8'h00)},
                {vec[i].v, vec[i].l, vec[i].b, vec[i].d, (vec[i].v ? vec[i].f : 8'h00)});
            start     = vec[i].st;
            out_ready = vec[i].rdy;
        end
        start = 1'b0;
    endtask

    logic [7:0] pat2 [10];

    initial begin
        pat2 = '{8'h00, 8'h01, 8'hC0, 8'h07, 8'hF0, 8'h1F, 8'hFC, 8'h7F, 8'hFF, 8'h00};

        // scenario A: full run with start pulses while busy (indices 0..11)
        add(0, 1, 1, 0, 8'h00, 1, 0);
        add(1, 1, 1, 0, 8'h01, 1, 0);
        add(0, 1, 1, 1, 8'hC0, 1, 0);
        add(1, 1, 0, 0, 8'h00, 1, 0);
        add(0, 1, 0, 0, 8'h00, 1, 0);
        add(0, 1, 1, 0, 8'h00, 1, 0);
        add(0, 1, 1, 0, 8'h01, 1, 0);
        add(0, 1, 1, 1, 8'hC0, 1, 0);
        add(0, 1, 0, 0, 8'h00, 1, 0);
        add(0, 1, 0, 0, 8'h00, 1, 0);
        add(0, 1, 0, 0, 8'h00, 0, 1);
        add(0, 1, 0, 0, 8'h00, 0, 1);
        // scenario B: back-pressure on flit 2 for four cycles (indices 12..26)
        add(0, 1, 1, 0, 8'h00, 1, 0);
        add(0, 1, 1, 0, 8'h01, 1, 0);
        add(0, 0, 1, 1, 8'hC0, 1, 0);
        add(0, 0, 1, 1, 8'hC0, 1, 0);
        add(0, 0, 1, 1, 8'hC0, 1, 0);
        add(0, 0, 1, 1, 8'hC0, 1, 0);
        add(0, 1, 1, 1, 8'hC0, 1, 0);
        add(0, 1, 0, 0, 8'h00, 1, 0);
        add(0, 1, 0, 0, 8'h00, 1, 0);
        add(0, 1, 1, 0, 8'h00, 1, 0);
        add(0, 1, 1, 0, 8'h01, 1, 0);
        add(0, 1, 1, 1, 8'hC0, 1, 0);
        add(0, 1, 0, 0, 8'h00, 1, 0);
        add(0, 1, 0, 0, 8'h00, 1, 0);
        add(0, 1, 0, 0, 8'h00, 0, 1);

        rst = 1'b1; start = 1'b0; out_ready = 1'b0;
        start2 = 1'b0; ready2 = 1'b1; inj_bad = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;

        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            chk($sformatf("reset_idle%0d", k), {v1, l1, busy1, done1, b1, a1}, 32'h0);
            chk($sformatf("reset_idle2_%0d", k), {v2, l2, busy2, done2, b2, a2}, 32'h0);
        end

        run_table("runA", 0, 12);
        run_table("bp", 12, 15);
`ifdef ADDER_INJ_CHECK_EN
        chk("err_clean", {15'h0, err1, ecnt1}, 32'h0);
`endif

        // reset during packet 1, flit 1
        start = 1'b1; out_ready = 1'b1;
        for (int k = 0; k < 7; k++) begin
            @(negedge clk);
            start = 1'b0;
        end
        rst = 1'b1;
        @(negedge clk);
        chk("mid_rst", {v1, l1, busy1, done1, b1, a1}, 32'h0);
        rst = 1'b0;
        run_table("rerun", 0, 12);

`ifdef ADDER_INJ_CHECK_EN
        inj_bad = 1'b1;
        run_table("inj", 0, 12);
        chk("err_set", {15'h0, err1, ecnt1}, {15'h0, 1'b1, 16'd2});
        inj_bad = 1'b0;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("err_clear", {14'h0, v1, err1, ecnt1}, {14'h0, 1'b1, 1'b0, 16'd0});
`endif

        // wide packet, no gap, pattern wraps after 2N
        start2 = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            start2 = 1'b0;
            chk($sformatf("wrap_flit%0d", i), {v2, l2, busy2, b2, a2},
                {1'b1, (i == 9), 1'b1, pat2[i]});
        end
        @(negedge clk);
        chk("wrap_done", {v2, l2, busy2, done2}, {1'b0, 1'b0, 1'b0, 1'b1});
`ifdef ADDER_INJ_CHECK_EN
        chk("wrap_err", {15'h0, err2, ecnt2}, 32'h0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
